// File: rtl/sorter_pkg.sv
// Shared types and the compare helper for the streaming insertion sorter.
// Samples are widened to MAX_W by the caller, so WIDTH must stay below MAX_W.
package sorter_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  localparam int MAX_W = 64;

  function automatic logic cmp_lt(input logic [MAX_W-1:0] a,
                                  input logic [MAX_W-1:0] b,
                                  input logic             signed_mode);
    if (signed_mode) begin
      return $signed(a) < $signed(b);
    end
    return a < b;
  endfunction

endpackage

// File: rtl/sorter_cell.sv
// One slot of the insertion array: decides whether the incoming sample lands at or
// below this slot and produces the slot's next value (keep, shift from left, or take x).
module sorter_cell
  import sorter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] left_i,
  input  logic             left_go_i,
  input  logic             valid_i,
  input  logic             dir_i,
  output logic             go_o,
  output logic [WIDTH-1:0] next_o,
  output logic [WIDTH-1:0] slot_o
);

  localparam logic SMODE = (SIGNED != 0);

  logic [WIDTH-1:0] slot_q;
  logic [MAX_W-1:0] x_ext;
  logic [MAX_W-1:0] slot_ext;

  function automatic logic [MAX_W-1:0] widen(input logic [WIDTH-1:0] v);
    return {{(MAX_W-WIDTH){SMODE & v[WIDTH-1]}}, v};
  endfunction

  assign x_ext    = widen(x_i);
  assign slot_ext = widen(slot_q);

  // Empty slots always yield, so the go flags form a monotonic 0..0 1..1 pattern.
  assign go_o   = ~valid_i | (dir_i ? cmp_lt(slot_ext, x_ext, SMODE)
                                    : cmp_lt(x_ext, slot_ext, SMODE));
  assign next_o = go_o ? (left_go_i ? left_i : x_i) : slot_q;
  assign slot_o = slot_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot_q <= '0;
    end else if (load_i) begin
      slot_q <= next_o;
    end
  end

endmodule

// File: rtl/param_insertion_sorter.sv
// Streaming insertion sorter: collects up to DEPTH samples sorted on arrival, then drains
// them in order over valid/ready. First out_valid one cycle after the last accept.
module param_insertion_sorter
  import sorter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             descend,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             dir_q, dir_d;

  logic             accept;
  logic             frame_done;
  logic             xfer;
  logic             dir_cur;
  logic [CW-1:0]    nxt_ptr;
  logic [WIDTH-1:0] rd_val;

  logic             go_w   [DEPTH];
  logic [WIDTH-1:0] next_w [DEPTH];
  logic [WIDTH-1:0] slot_w [DEPTH];

  assign accept     = in_valid & in_ready_q;
  assign frame_done = accept & (in_last | (count_q == CW'(DEPTH - 1)));
  assign xfer       = out_valid_q & out_ready;
  // Direction latches with the first sample; later toggles within the frame are ignored.
  assign dir_cur    = (count_q == '0) ? descend : dir_q;
  assign nxt_ptr    = rd_ptr_q + CW'(1);

  for (genvar j = 0; j < DEPTH; j++) begin : g_cell
    sorter_cell #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
    ) u_cell (
      .CLK       (CLK),
      .RESET     (RESET),
      .load_i    (accept),
      .x_i       (in_data),
      .left_i    ((j == 0) ? '0 : slot_w[(j == 0) ? 0 : j-1]),
      .left_go_i ((j == 0) ? 1'b0 : go_w[(j == 0) ? 0 : j-1]),
      .valid_i   (CW'(j) < count_q),
      .dir_i     (dir_cur),
      .go_o      (go_w[j]),
      .next_o    (next_w[j]),
      .slot_o    (slot_w[j])
    );
  end

  always_comb begin
    rd_val = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (nxt_ptr == CW'(j)) begin
        rd_val = slot_w[j];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (frame_done)          state_d = DRAIN;
      DRAIN:   if (xfer && out_last_q)  state_d = COLLECT;
      default:                          state_d = COLLECT;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    dir_d       = dir_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          count_d = count_q + CW'(1);
          dir_d   = dir_cur;
          if (frame_done) begin
            // Slot 0 is being written on this same edge, so take its next value.
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = next_w[0];
            out_last_d  = (count_q == '0);
            rd_ptr_d    = '0;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (out_last_q) begin
            count_d     = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
          end else begin
            rd_ptr_d   = nxt_ptr;
            out_data_d = rd_val;
            out_last_d = (nxt_ptr == count_q - CW'(1));
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      dir_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      dir_q       <= dir_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule
